ascon_serial_collector: RTL

// - Downstream of the Ascon encrypt/decrypt top. Deserialises its LSB-first serial result streams
//   (ciphertext + tag, or plaintext + tag) into parallel words.
// - Presents each result once on a valid/ack handshake to the host-side register file.
// - Records the direction of each result and the decrypt authentication verdict.

---
 rtl/ascon_pkg.sv | 18 +
 rtl/ascon_edge_det.sv | 35 +++
 rtl/ascon_serial_collector.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon collector types and helpers.
package ascon_pkg;

  localparam int unsigned ASCON_TAG_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } coll_state_e;

  // Number of serial bits needed to cover both text and tag lanes.
  function automatic int unsigned max_len(input int unsigned y, input int unsigned t);
    return (y > t) ? y : t;
  endfunction

endpackage

// File: rtl/ascon_edge_det.sv
// Rising-edge detector on the two ready levels; encrypt wins a simultaneous rise.
module ascon_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic enc_ready,
  input  logic dec_ready,
  output logic start_c,
  output logic dir_c
);

  logic enc_q;
  logic dec_q;
  logic enc_rise;
  logic dec_rise;

  // Previous-cycle levels; tracked in every collector state.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      enc_q <= enc_ready;
      dec_q <= dec_ready;
    end
  end

  // Start on either rise; direction is decrypt only when encrypt did not rise.
  always_comb begin
    enc_rise = enc_ready & ~enc_q;
    dec_rise = dec_ready & ~dec_q;
    start_c  = enc_rise | dec_rise;
    dir_c    = dec_rise & ~enc_rise;
  end

endmodule

// File: rtl/ascon_serial_collector.sv
// Deserialises the Ascon LSB-first result lanes into parallel words and
// presents each result once on a valid/ack handshake.
// Optional: ASCON_COLLECT_TAG_CMP_EN adds exp_tagxSI / tag_matchxSO.
module ascon_serial_collector
  import ascon_pkg::*;
#(
  parameter int unsigned Y = 32,
  parameter int unsigned T = ASCON_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_readyxSI,
  input  logic         dec_readyxSI,
  input  logic         ctxSI,
  input  logic         enc_tagxSI,
  input  logic         ptxSI,
  input  logic         dec_tagxSI,
  input  logic         authxSI,
  input  logic         ackxSI,
  output logic [Y-1:0] dataxSO,
  output logic [T-1:0] tagxSO,
  output logic         validxSO,
  output logic         is_decxSO,
  output logic         auth_okxSO,
  output logic         busyxSO
`ifdef ASCON_COLLECT_TAG_CMP_EN
  ,
  input  logic [T-1:0] exp_tagxSI,
  output logic         tag_matchxSO
`endif
);

  localparam int unsigned N     = max_len(Y, T);
  localparam int unsigned CNT_W = $clog2(N + 1);

  coll_state_e      state_q;
  coll_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_c;
  logic             dir_c;
  logic             shift_c;
  logic             last_c;
  logic             text_bit_c;
  logic             tag_bit_c;
  logic [Y-1:0]     data_d_c;
  logic [T-1:0]     tag_d_c;

  ascon_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .enc_ready (enc_readyxSI),
    .dec_ready (dec_readyxSI),
    .start_c   (start_c),
    .dir_c     (dir_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; starts outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = ALIGN;
      ALIGN:   state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(N - 1)) state_d = HOLD;
      HOLD:    if (ackxSI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select and bit-position decode for the next data/tag words.
  always_comb begin
    shift_c    = (state_q == SHIFT);
    last_c     = shift_c && (cnt_q == CNT_W'(N - 1));
    text_bit_c = is_decxSO ? ptxSI : ctxSI;
    tag_bit_c  = is_decxSO ? dec_tagxSI : enc_tagxSI;
    data_d_c   = dataxSO;
    tag_d_c    = tagxSO;
    if (shift_c) begin
      for (int unsigned i = 0; i < Y; i++) begin
        if (cnt_q == CNT_W'(i)) data_d_c[i] = text_bit_c;
      end
      for (int unsigned i = 0; i < T; i++) begin
        if (cnt_q == CNT_W'(i)) tag_d_c[i] = tag_bit_c;
      end
    end
  end

  // Collected words, bit counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataxSO    <= '0;
      tagxSO     <= '0;
      validxSO   <= 1'b0;
      busyxSO    <= 1'b0;
      is_decxSO  <= 1'b0;
      auth_okxSO <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dataxSO  <= data_d_c;
      tagxSO   <= tag_d_c;
      validxSO <= (state_d == HOLD);
      busyxSO  <= (state_d == ALIGN) || (state_d == SHIFT);
      if ((state_q == IDLE) && start_c) is_decxSO <= dir_c;
      if (last_c) auth_okxSO <= is_decxSO & authxSI;
      if (shift_c && !last_c) cnt_q <= cnt_q + CNT_W'(1);
      else                    cnt_q <= '0;
    end
  end

`ifdef ASCON_COLLECT_TAG_CMP_EN
  // Tag comparison captured with the final bit; only meaningful while held.
  always_ff @(posedge clk) begin
    if (rst)                   tag_matchxSO <= 1'b0;
    else if (last_c)           tag_matchxSO <= (tag_d_c == exp_tagxSI);
    else if (state_d != HOLD)  tag_matchxSO <= 1'b0;
  end
`endif

endmodule
